// File: rtl/karatsuba_pipe.sv
// Three-stage pipelined Karatsuba multiplier with exact/approximate modes,
// valid/ready handshakes, a global backpressure stall and a sideband tag.
module karatsuba_pipe #(
    parameter int unsigned N     = 64,
    parameter int unsigned T     = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_a,
    input  logic [N-1:0]       in_b,
    input  logic               in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*N-1:0]     out_p,
    output logic               out_mode,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int unsigned K    = N / 2;
    localparam int unsigned S_W  = K + 1;
    localparam int unsigned M_W  = 2 * K;
    localparam int unsigned M3_W = 2 * K + 2;
    localparam int unsigned P_W  = 2 * N;
    localparam int unsigned PF_W = 2 * N + 2;

    localparam logic [N-1:0] APPROX_MASK = ~((N'(1) << T) - N'(1));

    logic stall;
    logic advance;

    logic [N-1:0] a_prep;
    logic [N-1:0] b_prep;

    logic             v1;
    logic             mode1;
    logic [TAG_W-1:0] tag1;
    logic [K-1:0]     ah;
    logic [K-1:0]     al;
    logic [K-1:0]     bh;
    logic [K-1:0]     bl;
    logic [S_W-1:0]   s1;
    logic [S_W-1:0]   s2;

    logic             v2;
    logic             mode2;
    logic [TAG_W-1:0] tag2;
    logic [M_W-1:0]   m1;
    logic [M_W-1:0]   m2;
    logic [M3_W-1:0]  m3;

    logic [M3_W-1:0]  mid;

    // Whole pipeline freezes while a result waits at the output.
    assign stall    = out_valid & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = ~stall;

    // Approximate mode clears the low T bits of both operands.
    always_comb begin
        a_prep = in_a;
        b_prep = in_b;
        if (in_mode) begin
            a_prep = in_a & APPROX_MASK;
            b_prep = in_b & APPROX_MASK;
        end
    end

    // Stage 1: split halves and form the half sums with carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            mode1 <= 1'b0;
            tag1  <= '0;
            ah    <= '0;
            al    <= '0;
            bh    <= '0;
            bl    <= '0;
            s1    <= '0;
            s2    <= '0;
        end else if (advance) begin
            v1    <= in_valid;
            mode1 <= in_mode;
            tag1  <= in_tag;
            ah    <= a_prep[N-1:K];
            al    <= a_prep[K-1:0];
            bh    <= b_prep[N-1:K];
            bl    <= b_prep[K-1:0];
            s1    <= S_W'(a_prep[N-1:K]) + S_W'(a_prep[K-1:0]);
            s2    <= S_W'(b_prep[N-1:K]) + S_W'(b_prep[K-1:0]);
        end
    end

    // Stage 2: the three partial products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2    <= 1'b0;
            mode2 <= 1'b0;
            tag2  <= '0;
            m1    <= '0;
            m2    <= '0;
            m3    <= '0;
        end else if (advance) begin
            v2    <= v1;
            mode2 <= mode1;
            tag2  <= tag1;
            m1    <= M_W'(ah) * M_W'(bh);
            m2    <= M_W'(al) * M_W'(bl);
            m3    <= M3_W'(s1) * M3_W'(s2);
        end
    end

    // Middle term; m3 >= m1 + m2 always, so this never wraps.
    assign mid = m3 - M3_W'(m1) - M3_W'(m2);

    // Stage 3: recombine at full width; the top two bits are always zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            out_tag   <= '0;
            out_p     <= '0;
        end else if (advance) begin
            out_valid <= v2;
            out_mode  <= mode2;
            out_tag   <= tag2;
            out_p     <= P_W'((PF_W'(m1) << N) + (PF_W'(mid) << K) + PF_W'(m2));
        end
    end

endmodule

// File: tb/tb_karatsuba_pipe.sv
// Self-checking bench for karatsuba_pipe: directed corner cases plus a long
// randomized run scored against a plain-arithmetic reference queue.
module tb_karatsuba_pipe;

    localparam int unsigned N     = 64;
    localparam int unsigned T     = 8;
    localparam int unsigned TAG_W = 4;

    typedef struct packed {
        logic [2*N-1:0]   p;
        logic             mode;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [N-1:0]       in_a;
    logic [N-1:0]       in_b;
    logic               in_mode;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [2*N-1:0]     out_p;
    logic               out_mode;
    logic [TAG_W-1:0]   out_tag;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb_q[$];

    karatsuba_pipe #(.N(N), .T(T), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_mode  (out_mode),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference product: optional truncation then a plain wide multiply.
    function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] a, input logic [N-1:0] b,
                                                input logic mode);
        logic [N-1:0] mask;
        logic [N-1:0] ap;
        logic [N-1:0] bp;
        mask = ~((N'(1) << T) - N'(1));
        ap = mode ? (a & mask) : a;
        bp = mode ? (b & mask) : b;
        return (2*N)'(ap) * (2*N)'(bp);
    endfunction

    function automatic logic [N-1:0] pick_operand();
        logic [N-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '1;
            1:       v = N'($urandom_range(0, 1023));
            2:       v = {32'hFFFF_FFFF, $urandom};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: samples handshakes mid-cycle, checks order, values and stall hold.
    initial begin
        exp_t e;
        logic             hold_vld;
        logic [2*N-1:0]   hold_p;
        logic             hold_mode;
        logic [TAG_W-1:0] hold_tag;
        hold_vld  = 1'b0;
        hold_p    = '0;
        hold_mode = 1'b0;
        hold_tag  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                hold_vld = 1'b0;
            end else begin
                if (hold_vld) begin
                    check("hold_valid", 128'(out_valid), 128'(1'b1));
                    check("hold_p", out_p, hold_p);
                    check("hold_mode", 128'(out_mode), 128'(hold_mode));
                    check("hold_tag", 128'(out_tag), 128'(hold_tag));
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("spurious_out", 128'(out_valid), 128'(1'b0));
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_p", out_p, e.p);
                        check("sb_mode", 128'(out_mode), 128'(e.mode));
                        check("sb_tag", 128'(out_tag), 128'(e.tag));
                    end
                end
                hold_vld  = out_valid && !out_ready;
                hold_p    = out_p;
                hold_mode = out_mode;
                hold_tag  = out_tag;
                if (in_valid && in_ready) begin
                    e.p    = ref_prod(in_a, in_b, in_mode);
                    e.mode = in_mode;
                    e.tag  = in_tag;
                    sb_q.push_back(e);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*N-1:0]   snap_p;
        logic [TAG_W-1:0] snap_tag;
        logic             snap_mode;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_mode   = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) step();

        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_out_p", out_p, 128'(0));
        check("rst_out_tag", 128'(out_tag), 128'(0));
        check("rst_out_mode", 128'(out_mode), 128'(0));
        rst = 1'b0;
        check("rst_in_ready", 128'(in_ready), 128'(1'b1));

        // All-ones exact product and three-cycle latency.
        in_valid = 1'b1;
        in_a     = '1;
        in_b     = '1;
        in_mode  = 1'b0;
        in_tag   = 4'd3;
        step();
        in_valid = 1'b0;
        step();
        check("lat_early", 128'(out_valid), 128'(1'b0));
        step();
        check("lat_valid", 128'(out_valid), 128'(1'b1));
        check("ones_p", out_p, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        check("ones_tag", 128'(out_tag), 128'(4'd3));

        // Approximate versus exact on the same operands.
        repeat (3) step();
        in_valid = 1'b1;
        in_a     = 64'h1FF;
        in_b     = 64'h1FF;
        in_mode  = 1'b1;
        in_tag   = 4'd5;
        step();
        in_mode  = 1'b0;
        in_tag   = 4'd6;
        step();
        in_valid = 1'b0;
        step();
        check("approx_p", out_p, 128'h1_0000);
        check("approx_mode", 128'(out_mode), 128'(1'b1));
        step();
        check("exact_p", out_p, 128'h3_FC01);
        check("exact_mode", 128'(out_mode), 128'(1'b0));

        // Four back-to-back beats stream out on consecutive cycles.
        repeat (3) step();
        for (int c = 1; c <= 7; c++) begin
            if (c <= 4) begin
                in_valid = 1'b1;
                in_a     = pick_operand();
                in_b     = pick_operand();
                in_mode  = 1'(c % 2);
                in_tag   = TAG_W'(c - 1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (c >= 3 && c <= 6) begin
                check("stream_valid", 128'(out_valid), 128'(1'b1));
                check("stream_tag", 128'(out_tag), 128'(c - 3));
            end
            if (c == 7) check("stream_end", 128'(out_valid), 128'(1'b0));
        end

        // Backpressure: three beats in flight, consumer stalls for five cycles.
        repeat (3) step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = pick_operand();
            in_b     = pick_operand();
            in_mode  = 1'b0;
            in_tag   = TAG_W'(8 + i);
            step();
        end
        in_a      = pick_operand();
        in_b      = pick_operand();
        in_tag    = 4'd11;
        snap_p    = out_p;
        snap_tag  = out_tag;
        snap_mode = out_mode;
        check("stall_first_tag", 128'(out_tag), 128'(4'd8));
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", 128'(in_ready), 128'(1'b0));
            check("stall_valid", 128'(out_valid), 128'(1'b1));
            step();
            check("stall_p", out_p, snap_p);
            check("stall_tag", 128'(out_tag), 128'(snap_tag));
            check("stall_mode", 128'(out_mode), 128'(snap_mode));
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (8) step();
        check("drain_empty", 128'(sb_q.size()), 128'(0));
        check("drain_idle", 128'(out_valid), 128'(1'b0));

        // Reset while beats are in flight discards them.
        repeat (2) step();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_a     = pick_operand() | 64'h1;
            in_b     = pick_operand() | 64'h1;
            in_mode  = 1'b1;
            in_tag   = TAG_W'(12 + i);
            step();
        end
        in_valid = 1'b0;
        step();
        check("pre_rst_valid", 128'(out_valid), 128'(1'b1));
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 128'(out_valid), 128'(1'b0));
        check("mid_rst_p", out_p, 128'(0));
        check("mid_rst_tag", 128'(out_tag), 128'(0));
        check("mid_rst_mode", 128'(out_mode), 128'(0));
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_rst_quiet", 128'(out_valid), 128'(1'b0));
        end

        // Long random run with random backpressure.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = pick_operand();
            in_b      = pick_operand();
            in_mode   = 1'($urandom_range(0, 1));
            in_tag    = TAG_W'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() == 0 && !out_valid) break;
            step();
        end
        step();
        check("rand_drain_empty", 128'(sb_q.size()), 128'(0));
        check("rand_drain_idle", 128'(out_valid), 128'(1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
